addsub_serial: RTL and testbench
================================

ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 16, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port op, input, 1, 0 = a+b, 1 = a-b.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, signed two's-complement operands.
REQ-008 The block SHALL have port ready, output, 1, high when a start will be accepted.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port result, output, WIDTH, sum or difference.
REQ-011 The block SHALL have ports cf, zf, sf, of, output, 1 each: carry/borrow, zero, sign, signed overflow.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN, DONE; ready = 1 only in IDLE.
REQ-013 In IDLE, start = 1 at a clock edge SHALL latch a, b and op, clear the chunk counter, set the carry register to op, and move to RUN.
REQ-014 In IDLE, start = 0 SHALL hold state and all outputs.
REQ-015 For op = 1, the latched b SHALL be bitwise inverted with carry-in 1 (two's-complement subtract); op = 0 SHALL use b unchanged with carry-in 0.
REQ-016 Each RUN cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of a and of the op-adjusted b, plus the carry register. It SHALL write the CHUNK-bit sum into the same bit slice of result and store the chunk carry-out.
REQ-017 Chunks SHALL be processed LSB first; k SHALL run 0 .. N-1 with N = WIDTH/CHUNK, and no chunk SHALL be skipped or repeated.
REQ-018 After the edge that processes chunk N-1, the FSM SHALL enter DONE; done SHALL be 1 for exactly that one cycle, then the FSM SHALL return to IDLE.
REQ-019 Latency: with start sampled at edge E, done SHALL be high in the cycle after edge E+N; for WIDTH=64 and CHUNK=16, done SHALL be high 4 cycles after the start edge.
REQ-020 CHUNK = WIDTH SHALL be legal (N = 1, single RUN cycle).
REQ-021 On the DONE transition, flags SHALL be set as follows:
- zf = (result == 0)
- sf = result[WIDTH-1]
- cf = final carry-out for add; inverted final carry-out (borrow) for sub
- of = 1 iff the effective operand signs are equal and differ from the result sign
REQ-022 result and flags SHALL hold their values from DONE until the next accepted start; result bits MAY change chunk by chunk during RUN, and flags SHALL NOT change during RUN.
REQ-023 start in RUN or DONE SHALL be ignored and SHALL NOT be queued; a, b and op changes during RUN SHALL NOT affect the operation in flight.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; carry out of bit WIDTH-1 SHALL appear only in cf.

Reset
REQ-025 rst = 1 SHALL immediately, without a clock edge, force the following: state IDLE, result 0, cf/zf/sf/of 0, done 0, chunk counter 0, carry register 0.
REQ-026 rst asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-027 The first start accepted after rst deasserts SHALL behave exactly as from power-up IDLE.

Verification
REQ-028 Sub, a=5, b=3 -> done after 4 cycles, result=2, cf=0, zf=0, sf=0, of=0.
REQ-029 Sub, a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF, cf=1, sf=1, zf=0, of=0; the borrow propagates across all 4 chunks.
REQ-030 Add, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, of=1, sf=1, cf=0, zf=0. Sub, a=0x8000_0000_0000_0000, b=1 -> result=0x7FFF_FFFF_FFFF_FFFF, of=1.
REQ-031 Add, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zf=1, cf=1. Sub, a=b=0x1234 -> result=0, zf=1, cf=0.
REQ-032 Sequence: start sub 9-4, then re-pulse start with a=100 at cycle 2, then assert rst at cycle 3 of a second op -> re-pulse ignored and first done shows 5; second op aborted: outputs 0, ready=1, no done.
REQ-033 Parameter sweep, CHUNK in {1, 8, 64} with WIDTH=64 -> latency is 64, 8 or 1 cycles, and result/flags match a 1000-vector random reference model.

Source files
------------

// File: rtl/addsub_serial.sv
// Chunk-serial signed add/subtract: one CHUNK-bit slice per cycle, LSB first.
// Latency: done is high in the cycle after edge E+N (N = WIDTH/CHUNK), E = start edge.
// Backpressure: start is accepted only while ready (IDLE); starts in RUN/DONE are dropped.
module addsub_serial #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // Operands are captured at start; b is stored already inverted for subtract
    // so the RUN datapath is a plain adder with carry-in seeded from op.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_cf;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;

    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_result_next;

    assign w_last = (r_cnt == LAST);
    assign result = r_result;
    assign cf     = r_cf;
    assign zf     = r_zf;
    assign sf     = r_sf;
    assign of     = r_of;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Current chunk add and the full result with that chunk merged in.
    always_comb begin
        w_base    = 32'(r_cnt) * 32'(CHUNK);
        w_a_chunk = r_a[w_base +: CHUNK];
        w_b_chunk = r_b[w_base +: CHUNK];
        w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK + 1)'(r_carry);
        w_result_next = r_result;
        w_result_next[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    end

    // Operand capture, chunk sequencing, result and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cf     <= 1'b0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= op ? ~b : b;
            r_op    <= op;
            r_cnt   <= '0;
            r_carry <= op;
        end else if (r_state == RUN) begin
            r_result <= w_result_next;
            r_carry  <= w_sum[CHUNK];
            if (w_last) begin
                r_cnt <= '0;
                // Flags only move on the final chunk so they stay stable during RUN.
                r_zf <= ~|w_result_next;
                r_sf <= w_result_next[WIDTH-1];
                r_cf <= w_sum[CHUNK] ^ r_op;
                r_of <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (w_result_next[WIDTH-1] != r_a[WIDTH-1]);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: four instances (CHUNK 16, 1, 8, 64) share operands.
// Directed vectors with hand-computed results, abort/ignore sequence, random sweep.
// Each wait on done is bounded; timeouts surface as latency mismatches.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  st;
    logic        op;
    logic [63:0] a;
    logic [63:0] b;

    logic [63:0] res  [4];
    logic        rdy  [4];
    logic        dn   [4];
    logic        cf_o [4];
    logic        zf_o [4];
    logic        sf_o [4];
    logic        of_o [4];

    int total = 0;
    int bad   = 0;
    int lat   [4];
    int nd    [4];
    int nexp  [4] = '{4, 64, 8, 1};

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(64), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .start(st[0]), .op(op), .a(a), .b(b),
        .ready(rdy[0]), .done(dn[0]), .result(res[0]),
        .cf(cf_o[0]), .zf(zf_o[0]), .sf(sf_o[0]), .of(of_o[0]));

    addsub_serial #(.WIDTH(64), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(st[1]), .op(op), .a(a), .b(b),
        .ready(rdy[1]), .done(dn[1]), .result(res[1]),
        .cf(cf_o[1]), .zf(zf_o[1]), .sf(sf_o[1]), .of(of_o[1]));

    addsub_serial #(.WIDTH(64), .CHUNK(8)) u_c8 (
        .clk(clk), .rst(rst), .start(st[2]), .op(op), .a(a), .b(b),
        .ready(rdy[2]), .done(dn[2]), .result(res[2]),
        .cf(cf_o[2]), .zf(zf_o[2]), .sf(sf_o[2]), .of(of_o[2]));

    addsub_serial #(.WIDTH(64), .CHUNK(64)) u_c64 (
        .clk(clk), .rst(rst), .start(st[3]), .op(op), .a(a), .b(b),
        .ready(rdy[3]), .done(dn[3]), .result(res[3]),
        .cf(cf_o[3]), .zf(zf_o[3]), .sf(sf_o[3]), .of(of_o[3]));

    // Reference: {result, cf, zf, sf, of} from 65-bit arithmetic.
    function automatic logic [67:0] model(input logic o, input logic [63:0] x, input logic [63:0] y);
        logic [64:0] t;
        logic        ov;
        if (!o) begin
            t  = {1'b0, x} + {1'b0, y};
            ov = (x[63] == y[63]) && (t[63] != x[63]);
        end else begin
            t  = {1'b0, x} - {1'b0, y};
            ov = (x[63] != y[63]) && (t[63] != x[63]);
        end
        return {t[63:0], t[64], (t[63:0] == 64'd0), t[63], ov};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [67:0] obs, input logic [67:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [67:0] exp);
        for (int i = 0; i < 4; i++) begin
            chk(tag, i, {res[i], cf_o[i], zf_o[i], sf_o[i], of_o[i]}, exp);
        end
    endtask

    // Start all four instances on the same operands, scramble inputs during RUN,
    // then measure latency and done-pulse count per instance.
    task automatic run(input logic o, input logic [63:0] x, input logic [63:0] y);
        logic all_done;
        for (int i = 0; i < 4; i++) begin
            lat[i] = 0;
            nd[i]  = 0;
        end
        @(negedge clk);
        a = x; b = y; op = o; st = 4'hF;
        @(negedge clk);
        st = 4'h0; a = ~x; b = ~y; op = ~o;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (c == 1) begin
                for (int i = 0; i < 4; i++) chk("rdy_busy", i, 68'(rdy[i]), 68'd0);
            end
            all_done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (dn[i]) begin
                    nd[i]++;
                    if (lat[i] == 0) lat[i] = c;
                end
                if (lat[i] == 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (dn[i]) nd[i]++;
            chk("latency", i, 68'(lat[i]), 68'(nexp[i]));
            chk("done_cnt", i, 68'(nd[i]), 68'd1);
            chk("rdy_after", i, 68'(rdy[i]), 68'd1);
        end
    endtask

    initial begin
        logic [63:0] x;
        logic [63:0] y;
        logic        o;
        int          cnt;

        rst = 1'b1; st = 4'h0; op = 1'b0; a = '0; b = '0;
        #23;
        chk_all("reset_out", 68'd0);
        for (int i = 0; i < 4; i++) chk("reset_hs", i, {66'd0, rdy[i], dn[i]}, 68'b10);
        @(negedge clk);
        rst = 1'b0;

        run(1'b1, 64'd5, 64'd3);
        chk_all("sub_5_3", {64'd2, 4'b0000});
        run(1'b1, 64'd0, 64'd1);
        chk_all("sub_0_1", {64'hFFFF_FFFF_FFFF_FFFF, 4'b1010});
        run(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk_all("add_ovf", {64'h8000_0000_0000_0000, 4'b0011});
        run(1'b1, 64'h8000_0000_0000_0000, 64'd1);
        chk_all("sub_ovf", {64'h7FFF_FFFF_FFFF_FFFF, 4'b0001});
        run(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk_all("add_wrap", {64'd0, 4'b1100});
        run(1'b1, 64'h1234, 64'h1234);
        chk_all("sub_eq", {64'd0, 4'b0100});

        // Idle with start low: outputs must hold.
        a = 64'hDEAD; b = 64'hBEEF;
        repeat (3) @(negedge clk);
        chk_all("hold", {64'd0, 4'b0100});

        // Re-pulse of start during RUN is dropped, not queued.
        @(negedge clk);
        a = 64'd9; b = 64'd4; op = 1'b1; st = 4'h1;
        @(negedge clk);
        st = 4'h0;
        @(negedge clk);
        a = 64'd100; st = 4'h1;
        @(negedge clk);
        st = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("repulse_done", 0, 68'(dn[0]), 68'd1);
        chk("repulse_res", 0, 68'(res[0]), 68'd5);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dn[0]) cnt++;
        end
        chk("repulse_noq", 0, 68'(cnt), 68'd0);

        // Reset mid-RUN aborts the operation immediately.
        @(negedge clk);
        a = 64'd9; b = 64'd4; op = 1'b1; st = 4'h1;
        @(negedge clk);
        st = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out", 0, {res[0], cf_o[0], zf_o[0], sf_o[0], of_o[0]}, 68'd0);
        chk("abort_hs", 0, {66'd0, rdy[0], dn[0]}, 68'b10);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dn[0]) cnt++;
        end
        chk("abort_nodone", 0, 68'(cnt), 68'd0);

        run(1'b1, 64'd9, 64'd4);
        chk_all("after_rst", {64'd5, 4'b0000});

        for (int k = 0; k < 1000; k++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            o = 1'($urandom_range(0, 1));
            if (k % 10 == 0) y = x;
            if (k % 10 == 1) x = {1'b0, {63{1'b1}}};
            if (k % 10 == 2) x = {1'b1, 63'd0};
            run(o, x, y);
            chk_all("random", model(o, x, y));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
